// File: rtl/bin_timekeeper_if.sv
// bin_timekeeper_if: control/status bundle between a controller (master) and the timekeeper core (slave).
interface bin_timekeeper_if;
    logic       pps;
    logic       load;
    logic [4:0] hours_init;
    logic [1:0] set_sel;
    logic       set_inc;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       alarm_arm;
    logic       alarm_clr;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       sec_tick;
    logic       min_tick;
    logic       hour_tick;
    logic       day_tick;
    logic       pps_locked;
    logic       alarm;

    modport master (
        output pps, load, hours_init, set_sel, set_inc,
               alarm_hours, alarm_minutes, alarm_arm, alarm_clr,
        input  hours, minutes, seconds, sec_tick, min_tick, hour_tick, day_tick,
               pps_locked, alarm
    );

    modport slave (
        input  pps, load, hours_init, set_sel, set_inc,
               alarm_hours, alarm_minutes, alarm_arm, alarm_clr,
        output hours, minutes, seconds, sec_tick, min_tick, hour_tick, day_tick,
               pps_locked, alarm
    );
endinterface

// File: rtl/bin_timekeeper.sv
// bin_timekeeper: time-of-day core with PPS lock, watchdog fallback to an internal prescaler and manual set.
// Alarm logic is built only when BIN_TIMEKEEPER_ALARM_EN is defined.
module bin_timekeeper #(
    parameter int CLK_DIV   = 200,
    parameter int HOURS_MOD = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    bin_timekeeper_if.slave tk
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int WW = $clog2(2 * CLK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
    localparam logic [WW-1:0] W_DROP = WW'(2 * CLK_DIV - 2);
    localparam logic [4:0]    H_LAST = 5'(HOURS_MOD - 1);

    logic          r_sync1, r_sync2, r_hist, r_inc_s, r_inc_d, r_locked;
    logic [PW-1:0] r_presc;
    logic [WW-1:0] r_wd;
    logic [4:0]    r_hours;
    logic [5:0]    r_minutes, r_seconds;
    logic          r_sec_tick, r_min_tick, r_hour_tick, r_day_tick;
    logic          w_pps_edge, w_inc_edge, w_set, w_inc_go, w_strobe;
    logic          w_s_wrap, w_m_wrap, w_h_wrap, w_adv_s, w_adv_m, w_adv_h;
    logic [4:0]    w_h_init;

    assign w_pps_edge = r_sync2 & ~r_hist;
    assign w_inc_edge = r_inc_s & ~r_inc_d;
    assign w_set      = tk.set_sel != 2'b00;
    assign w_inc_go   = ~tk.load & w_set & w_inc_edge;
    // the prescaler keeps running while locked so a lost PPS falls back in phase with the last edge
    assign w_strobe   = ~tk.load & ~w_set & (r_locked ? w_pps_edge : (r_presc == P_LAST));
    assign w_s_wrap   = r_seconds == 6'd59;
    assign w_m_wrap   = r_minutes == 6'd59;
    assign w_h_wrap   = r_hours == H_LAST;
    assign w_adv_s    = w_strobe | (w_inc_go & (tk.set_sel == 2'b11));
    assign w_adv_m    = (w_strobe & w_s_wrap) | (w_inc_go & (tk.set_sel == 2'b10));
    assign w_adv_h    = (w_strobe & w_s_wrap & w_m_wrap) | (w_inc_go & (tk.set_sel == 2'b01));
    assign w_h_init   = (int'(tk.hours_init) >= HOURS_MOD) ? 5'd0 : tk.hours_init;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r_sync1, r_sync2, r_hist, r_inc_s, r_inc_d, r_locked} <= '0;
            r_presc     <= '0;
            r_wd        <= '0;
            r_hours     <= '0;
            r_minutes   <= '0;
            r_seconds   <= '0;
            {r_sec_tick, r_min_tick, r_hour_tick, r_day_tick} <= '0;
        end else begin
            r_sync1     <= tk.pps;
            r_sync2     <= r_sync1;
            r_hist      <= r_sync2;
            r_inc_s     <= tk.set_inc;
            r_inc_d     <= r_inc_s;
            r_presc     <= (tk.load | w_set | w_pps_edge | (r_presc == P_LAST)) ? '0 : r_presc + PW'(1);
            r_wd        <= w_pps_edge ? '0 : r_locked ? r_wd + WW'(1) : r_wd;
            r_locked    <= w_pps_edge | (r_locked & (r_wd != W_DROP));
            r_seconds   <= tk.load ? '0 : w_adv_s ? (w_s_wrap ? '0 : r_seconds + 6'd1) : r_seconds;
            r_minutes   <= tk.load ? '0 : w_adv_m ? (w_m_wrap ? '0 : r_minutes + 6'd1) : r_minutes;
            r_hours     <= tk.load ? w_h_init : w_adv_h ? (w_h_wrap ? '0 : r_hours + 5'd1) : r_hours;
            r_sec_tick  <= w_strobe;
            r_min_tick  <= w_strobe & w_s_wrap;
            r_hour_tick <= w_strobe & w_s_wrap & w_m_wrap;
            r_day_tick  <= w_strobe & w_s_wrap & w_m_wrap & w_h_wrap;
        end
    end

    assign tk.hours      = r_hours;
    assign tk.minutes    = r_minutes;
    assign tk.seconds    = r_seconds;
    assign tk.sec_tick   = r_sec_tick;
    assign tk.min_tick   = r_min_tick;
    assign tk.hour_tick  = r_hour_tick;
    assign tk.day_tick   = r_day_tick;
    assign tk.pps_locked = r_locked;

`ifdef BIN_TIMEKEEPER_ALARM_EN
    logic r_alarm;

    // matches against the freshly rolled time visible during the min_tick cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_alarm <= 1'b0;
        else r_alarm <= (tk.alarm_clr | ~tk.alarm_arm) ? 1'b0 :
            r_alarm | (r_min_tick & (r_hours == tk.alarm_hours) & (r_minutes == tk.alarm_minutes));
    end

    assign tk.alarm = r_alarm;
`else
    logic w_unused;

    assign w_unused = ^{tk.alarm_hours, tk.alarm_minutes, tk.alarm_arm, tk.alarm_clr};
    assign tk.alarm = 1'b0;
`endif
endmodule

// File: tb/tb_bin_timekeeper.sv
// tb_bin_timekeeper: random and directed stimulus; a time-of-day reference model feeds a scoreboard queue
// that a negedge monitor drains and compares against the core's outputs every cycle.
module tb_bin_timekeeper;
    localparam int C   = 10;
    localparam int HM  = 24;
    localparam int DAY = HM * 3600;
    localparam int N   = 16384;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [3:0] tick;
        logic       lk;
        logic       al;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   ps [0:N-1];
    bit   is [0:N-1];
    bit   pps_on;

    always #5 clk = ~clk;

    bin_timekeeper_if bus();

    bin_timekeeper #(.CLK_DIV(C), .HOURS_MOD(HM)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tk(bus.slave)
    );

    function automatic obs_t observe();
        return {bus.hours, bus.minutes, bus.seconds,
                {bus.day_tick, bus.hour_tick, bus.min_tick, bus.sec_tick}, bus.pps_locked, bus.alarm};
    endfunction

    function automatic bit ps_at(int i);
        return (i >= 1) ? ps[i] : 1'b0;
    endfunction

    function automatic bit is_at(int i);
        return (i >= 1) ? is[i] : 1'b0;
    endfunction

    function automatic int bump(int tod, logic [1:0] sel);
        int h, m, s;
        h = tod / 3600;
        m = (tod / 60) % 60;
        s = tod % 60;
        if (sel == 2'd1) h = (h + 1) % HM;
        if (sel == 2'd2) m = (m + 1) % 60;
        if (sel == 2'd3) s = (s + 1) % 60;
        return h * 3600 + m * 60 + s;
    endfunction

    // Reference model: seconds-of-day plus cycle arithmetic (phase origin, last PPS edge)
    int cyc, origin, last_pe, tod;
    bit have_pe;
    obs_t prev;

    always @(posedge clk) begin : model
        obs_t e;
        bit pe, ie, lk_pre, strobe;
        e = '0;
        if (!rst_n) begin
            cyc = 0; origin = 0; have_pe = 0; last_pe = 0; tod = 0;
        end else begin
            cyc++;
            ps[cyc] = bus.pps;
            is[cyc] = bus.set_inc;
            pe      = ps_at(cyc - 2) && !ps_at(cyc - 3);
            ie      = is_at(cyc - 1) && !is_at(cyc - 2);
            lk_pre  = have_pe && (cyc - 1 - last_pe) < 2 * C - 1;
            strobe  = !bus.load && bus.set_sel == 2'd0 && (lk_pre ? pe : ((cyc - origin) % C == 0));
            if (bus.load) tod = (int'(bus.hours_init) >= HM ? 0 : int'(bus.hours_init)) * 3600;
            else if (bus.set_sel != 2'd0 && ie) tod = bump(tod, bus.set_sel);
            else if (strobe) begin
                tod = (tod + 1) % DAY;
                e.tick = {tod == 0, tod % 3600 == 0, tod % 60 == 0, 1'b1};
            end
            if (bus.load || bus.set_sel != 2'd0 || pe) origin = cyc;
            if (pe) begin have_pe = 1; last_pe = cyc; end
            e.h  = 5'(tod / 3600);
            e.m  = 6'((tod / 60) % 60);
            e.s  = 6'(tod % 60);
            e.lk = have_pe && (cyc - last_pe) < 2 * C - 1;
`ifdef BIN_TIMEKEEPER_ALARM_EN
            e.al = (bus.alarm_clr || !bus.alarm_arm) ? 1'b0 :
                   ((prev.tick[1] && prev.h == bus.alarm_hours && prev.m == bus.alarm_minutes) || prev.al);
`else
            e.al = 1'b0;
`endif
        end
        prev = e;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!rst_n) e = '0;
            a = observe();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL scoreboard @%0t: got %0d:%0d:%0d tick=%b lock=%b alarm=%b, expected %0d:%0d:%0d tick=%b lock=%b alarm=%b",
                         $time, a.h, a.m, a.s, a.tick, a.lk, a.al, e.h, e.m, e.s, e.tick, e.lk, e.al);
            end
        end
    end

    task automatic check(string name, int got, int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic pulse_inc();
        bus.set_inc = 1'b1;
        @(negedge clk);
        bus.set_inc = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_field(logic [1:0] sel, int n);
        bus.set_sel = sel;
        repeat (n) pulse_inc();
    endtask

    task automatic do_load(int h);
        bus.load = 1'b1;
        bus.hours_init = 5'(h);
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    initial begin
        bus.pps = 0; bus.load = 0; bus.hours_init = 0; bus.set_sel = 0; bus.set_inc = 0;
        bus.alarm_hours = 0; bus.alarm_minutes = 0; bus.alarm_arm = 0; bus.alarm_clr = 0;
        repeat (3) @(negedge clk);
        check("reset_state", int'(observe()), 0);
        rst_n = 1'b1;

        repeat (600) @(negedge clk);
        check("run600_minutes", int'(bus.minutes), 1);
        check("run600_seconds", int'(bus.seconds), 0);

        do_load(23);
        check("load_23", int'(bus.hours), 23);
        set_field(2'd2, 59);
        set_field(2'd3, 59);
        check("set_235959", int'({bus.hours, bus.minutes, bus.seconds}), int'({5'd23, 6'd59, 6'd59}));
        bus.set_sel = 2'd0;
        repeat (C) @(negedge clk);
        check("day_roll_time", int'({bus.hours, bus.minutes, bus.seconds}), 0);
        check("day_roll_ticks", int'({bus.day_tick, bus.hour_tick, bus.min_tick, bus.sec_tick}), 15);

        do_load(30);
        check("load_out_of_range", int'(bus.hours), 0);

        repeat (10) begin
            bus.pps = 1'b1;
            repeat (2) @(negedge clk);
            bus.pps = 1'b0;
            repeat (5) @(negedge clk);
        end
        check("pps_locked", int'(bus.pps_locked), 1);
        repeat (14) @(negedge clk);
        check("lock_held_18", int'(bus.pps_locked), 1);
        @(negedge clk);
        check("lock_drop_19", int'(bus.pps_locked), 0);
        repeat (30) @(negedge clk);

        do_load(5);
        set_field(2'd2, 58);
        check("set_min_58", int'(bus.minutes), 58);
        set_field(2'd2, 3);
        check("set_min_wrap", int'(bus.minutes), 1);
        check("set_hours_kept", int'(bus.hours), 5);
        check("set_sec_frozen", int'(bus.seconds), 0);
        bus.set_sel = 2'd0;

`ifdef BIN_TIMEKEEPER_ALARM_EN
        do_load(7);
        set_field(2'd2, 29);
        set_field(2'd3, 59);
        bus.alarm_hours = 5'd7; bus.alarm_minutes = 6'd30; bus.alarm_arm = 1'b1;
        bus.set_sel = 2'd0;
        repeat (C + 1) @(negedge clk);
        check("alarm_set", int'(bus.alarm), 1);
        bus.alarm_clr = 1'b1;
        @(negedge clk);
        bus.alarm_clr = 1'b0;
        check("alarm_clr", int'(bus.alarm), 0);
`endif

        for (int i = 0; i < 1500; i++) begin
            if (i % 250 == 0) pps_on = 1'($urandom_range(0, 1));
            bus.pps = pps_on && ($urandom_range(0, 6) == 0);
            bus.load = ($urandom_range(0, 299) == 0);
            bus.hours_init = 5'($urandom_range(0, 31));
            if (bus.set_sel == 2'd0) begin
                if ($urandom_range(0, 149) == 0) bus.set_sel = 2'($urandom_range(1, 3));
            end else if ($urandom_range(0, 29) == 0) bus.set_sel = 2'd0;
            bus.set_inc = 1'($urandom_range(0, 1));
            bus.alarm_hours = 5'($urandom_range(0, 23));
            bus.alarm_minutes = 6'($urandom_range(0, 59));
            bus.alarm_arm = ($urandom_range(0, 19) != 0);
            bus.alarm_clr = ($urandom_range(0, 49) == 0);
            @(negedge clk);
        end

        bus.pps = 0; bus.load = 0; bus.set_sel = 0; bus.set_inc = 0; bus.alarm_clr = 0;
        repeat (C * 3 + 3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", int'(observe()), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * C + 5) @(negedge clk);
        check("post_reset_seconds", int'(bus.seconds), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bin_timekeeper.md
# bin_timekeeper

Parametrised time-of-day core for the binary-clock family. It keeps hours, minutes and seconds with a configurable prescaler, and locks to an external PPS input with a watchdog that falls back to the internal prescaler. It supports field-by-field manual time setting and an optional alarm. Its outputs feed the row/column display scanner and any roll-driven logic downstream.

## Interface
- `CLK_DIV`, 200: clk cycles per internal second; ≥ 4.
- `HOURS_MOD`, 24: hour wrap value; 2..32.
- `clk` in 1: system clock; all state on posedge.
- `rst_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `pps` in 1: asynchronous pulse-per-second input.
- `load` in 1: synchronous strobe; loads `hours_init`, zeroes minutes/seconds.
- `hours_init` in 5: hour value for `load`.
- `set_sel` in 2: 00 run, 01 hours, 10 minutes, 11 seconds.
- `set_inc` in 1: synchronous level; rising edge increments the selected field.
- `alarm_hours` in 5, `alarm_minutes` in 6: alarm time.
- `alarm_arm` in 1: alarm enable level.
- `alarm_clr` in 1: clears `alarm`.
- `hours` out 5, `minutes` out 6, `seconds` out 6: current time.
- `sec_tick`, `min_tick`, `hour_tick`, `day_tick` out 1: single-cycle roll pulses.
- `pps_locked` out 1: seconds are currently sourced from PPS.
- `alarm` out 1: alarm flag.

## Operation
- Reset values:
  - All outputs 0.
  - Prescaler 0, watchdog 0, sync flops 0, `set_inc` edge register 0.
- PPS path:
  - `pps` passes through a 2-flop synchroniser plus a history flop.
  - `pps_edge` = sync2 & ~hist.
- Lock:
  - Any `pps_edge` sets `pps_locked` and clears the watchdog.
  - While locked, the watchdog increments each cycle.
  - On reaching 2*CLK_DIV−1 without an edge, `pps_locked` clears.
- Second strobe:
  - Locked: the strobe is `pps_edge`.
  - Unlocked: the strobe fires when the prescaler = CLK_DIV−1. The prescaler counts 0..CLK_DIV−1 and wraps.
  - Every `pps_edge` zeroes the prescaler, so fallback stays phase-aligned.
- Counting on strobe:
  - seconds 59→0 carries into minutes; minutes 59→0 carries into hours; hours HOURS_MOD−1→0.
  - Tick pulses assert for exactly the carries taken. `sec_tick` asserts on every strobe.
- Set mode (`set_sel`≠00):
  - Strobes are suppressed and the prescaler is held at 0.
  - A `set_inc` rising edge increments the selected field, wrapping within the field with no carry and no tick pulses.
  - Returning to 00 resumes counting from prescaler 0.
- Load:
  - `load` has highest priority below reset.
  - hours = `hours_init`, or 0 if `hours_init` ≥ HOURS_MOD.
  - minutes = seconds = 0; no ticks issued; prescaler zeroed.
- Priority per cycle: load > set increment > strobe.
- Width rules:
  - Prescaler and watchdog widths come from $clog2 of their terminal counts.
  - Field compares are exact equality.

## Timing
- `pps` first sampled high at edge N: sync2 high after N+1; the field update and `sec_tick` occur at edge N+2.
- Fields and tick pulses are registered together. A tick is high during the cycle in which the new field value is first visible.
- Internal mode: `sec_tick` recurs every CLK_DIV cycles, with the first tick CLK_DIV edges after reset release.
- Watchdog: `pps_locked` falls at the 2*CLK_DIV−1-th edge after the last `pps_edge`.
  - The internal strobe may fire in that same cycle, using the prescaler value.
- `set_inc`: field changes at the edge after the first edge sampling `set_inc`=1 following a 0.
- `rst_n` low mid-operation clears everything immediately. Ticks never extend across reset.

## Configuration
- `BIN_TIMEKEEPER_ALARM_EN` defined:
  - `alarm` sets on a `min_tick` cycle when `alarm_arm`=1 and the new hours/minutes equal `alarm_hours`/`alarm_minutes`.
  - `alarm` clears on `alarm_clr`=1 or `alarm_arm`=0. Clear wins over a simultaneous set.
  - Alarm updates are registered.
- Undefined:
  - No alarm logic is built; `alarm` is tied 0.
  - Alarm inputs stay in the port list and are ignored.

## Test plan
- CLK_DIV=10, no PPS, run 600 cycles → `sec_tick` every 10 cycles; minutes=1, seconds=0 at cycle 600; one `min_tick`.
- `load` with `hours_init`=23, set minutes=59 and seconds=59 via set mode, return to run → next strobe gives 00:00:00 with `sec_tick`, `min_tick`, `hour_tick`, `day_tick` all high for one cycle.
- `load` with `hours_init`=30, HOURS_MOD=24 → hours=0.
- PPS edges every 7 cycles (CLK_DIV=10) → `pps_locked`=1, seconds advance every 7 cycles. Stop PPS → lock drops 19 cycles after the last edge, internal ticks continue at 10-cycle spacing aligned to that edge.
- `set_sel`=10, three `set_inc` pulses from minutes=58 → minutes 59, 0, 1; hours unchanged; no ticks; seconds frozen.
- ALARM_EN, alarm 07:30 armed, time 07:29:59 → `alarm`=1 after the next strobe. `alarm_clr` → 0. Assert `rst_n` low mid-count → all outputs 0 asynchronously.
